// File: rtl/serial_digit_adder_pkg.sv
// Shared types for the serial digit adder: FSM state encoding and the
// helper that derives how many digit steps one operation takes.
package serial_digit_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_steps(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_digit_adder_adder_digit.sv
// Purely combinational DIGIT-bit ripple adder; also exposes the carry into
// its top bit so the caller can form two's-complement overflow.
module adder_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  // Ripple the carry bit by bit; c[i] is the carry into bit i.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle adder/subtractor: consumes DIGIT bits of each operand per clock,
// LSB digit first, holding the carry in a register between digits.
module serial_digit_adder
  import serial_digit_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = calc_steps(WIDTH, DIGIT);
  localparam int CW    = $clog2(STEPS + 1);

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] sumreg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             coutreg;
  logic             ovfreg;

  logic [DIGIT-1:0] dsum;
  logic             dco;
  logic             dmsb;

  adder_digit #(.DIGIT(DIGIT)) u_digit (
    .x     (areg[DIGIT-1:0]),
    .y     (breg[DIGIT-1:0]),
    .ci    (carry),
    .s     (dsum),
    .co    (dco),
    .c_msb (dmsb)
  );

  // Subtraction is a + ~b + 1, so B is inverted and the carry seeded with 1
  // at capture time; each RUN cycle then retires one digit into the result's
  // MSB end so that after STEPS shifts the full word is aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      areg    <= '0;
      breg    <= '0;
      sumreg  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      coutreg <= 1'b0;
      ovfreg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            areg  <= a;
            breg  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          areg   <= areg >> DIGIT;
          breg   <= breg >> DIGIT;
          sumreg <= (sumreg >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
          carry  <= dco;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(STEPS - 1)) begin
            coutreg <= dco;
            ovfreg  <= dco ^ dmsb;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sumreg;
  assign cout = coutreg;
  assign ovf  = ovfreg;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Scoreboard bench for serial_digit_adder at DIGIT = 2, 1 and 8 (WIDTH = 8);
// stimulus pushes hand-computed results, a monitor pops them on each done.
module tb_serial_digit_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic [2:0] busy_w;
  logic [2:0] done_w;
  logic [7:0] sum_w  [3];
  logic [2:0] cout_w;
  logic [2:0] ovf_w;

  int   checks;
  int   errors;
  int   cur;
  int   steps [3];
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic       busy_s;
  logic       done_s;

  serial_digit_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start[0]), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0])
  );

  serial_digit_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start[1]), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1])
  );

  serial_digit_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start[2]), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2])
  );

  assign busy_s = busy_w[cur];
  assign done_s = done_w[cur];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Every done pulse must match the oldest outstanding expectation of that instance.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_w[i] === 1'b1) begin
        exp_t e;
        bit   has;
        has = 0;
        e   = '0;
        case (i)
          0: if (q0.size() > 0) begin e = q0.pop_front(); has = 1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); has = 1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); has = 1; end
        endcase
        if (!has) begin
          checkOutput($sformatf("unexpected_done_%0d", i), 32'd1, 32'd0);
        end else begin
          checkOutput($sformatf("sum_%0d", i), 32'(sum_w[i]), 32'(e.sum));
          checkOutput($sformatf("cout_%0d", i), 32'(cout_w[i]), 32'(e.cout));
          checkOutput($sformatf("ovf_%0d", i), 32'(ovf_w[i]), 32'(e.ovf));
        end
      end
    end
  end

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after DONE.
  task automatic applyStimulus(input int sel, input logic [7:0] va, input logic [7:0] vb,
                               input logic vcin, input logic vsub, input logic [7:0] esum,
                               input logic ecout, input logic eovf, input int intrudeRun,
                               input bit intrudeDone);
    exp_t e;
    int   nbusy;
    bit   seen;
    cur = sel;
    e   = {esum, ecout, eovf};
    case (sel)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    a = va; b = vb; cin = vcin; sub = vsub;
    start = '0;
    start[sel] = 1'b1;
    @(posedge clk);
    #1;
    start = '0;
    a = 8'h5A; b = 8'hA5; cin = ~vcin; sub = ~vsub;
    nbusy = 0;
    seen  = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      start = '0;
      if (done_s === 1'b1) begin
        seen = 1;
        checkOutput("busy_in_done", 32'(busy_s), 32'd0);
      end else if (busy_s === 1'b1) begin
        nbusy++;
        if (intrudeRun > 0 && nbusy == intrudeRun) begin
          start[sel] = 1'b1;
          a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b0;
        end
      end
    end
    if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
    checkOutput("busy_cycles", 32'(nbusy), 32'(steps[sel]));
    if (intrudeDone) begin
      start[sel] = 1'b1;
      a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0;
    end
    @(negedge clk);
    start = '0;
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy_w[0]), 32'd0);
    checkOutput({tag, "_done"}, 32'(done_w[0]), 32'd0);
    checkOutput({tag, "_sum"},  32'(sum_w[0]),  32'd0);
    checkOutput({tag, "_cout"}, 32'(cout_w[0]), 32'd0);
    checkOutput({tag, "_ovf"},  32'(ovf_w[0]),  32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    cur    = 0;
    steps  = '{4, 8, 1};
    rst    = 1'b1;
    start  = '0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdleZero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleZero("idle");

    applyStimulus(0, 8'h0A, 8'h05, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("sum_hold", 32'(sum_w[0]), 32'h10);
      @(negedge clk);
    end

    for (int d = 0; d < 3; d++) begin
      if (d != 0) applyStimulus(d, 8'h0A, 8'h05, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 0, 0);
      applyStimulus(d, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0, 0);
      applyStimulus(d, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0);
      applyStimulus(d, 8'h03, 8'h05, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 0, 0);
      applyStimulus(d, 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 0, 0);
    end

    // Starts in RUN and DONE are dropped; the next start in IDLE is taken.
    applyStimulus(0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 2, 1);
    applyStimulus(0, 8'h20, 8'h30, 1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 0, 0);

    // Reset during the second RUN cycle aborts without a done pulse.
    cur = 0;
    a = 8'h55; b = 8'h0F; cin = 1'b0; sub = 1'b0;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkIdleZero("abort");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("abort_no_done", 32'(done_w[0]), 32'd0);
    applyStimulus(0, 8'h0A, 8'h05, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 0, 0);

    repeat (4) @(negedge clk);
    checkOutput("q0_drained", 32'(q0.size()), 32'd0);
    checkOutput("q1_drained", 32'(q1.size()), 32'd0);
    checkOutput("q2_drained", 32'(q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
